// File: rtl/axi_read_responder.sv
// axi_read_responder
//   AXI4 read-channel slave (AR/R only) backed by a word-addressed memory.
//   It serves FIXED and INCR bursts of up to 256 beats. There is a
//   programmable idle gap between the AR handshake and the first R beat.
//   A backdoor port can preload or patch the memory contents.
//
// Ports
//   i_clock, i_reset        clock and synchronous active-high reset
//   i_axi_ar*, o_axi_arready  read address channel (addr, valid, id, len, size, burst)
//   o_axi_r*, i_axi_rready    read data channel (data, valid, resp, id, last)
//   i_bd_wen/waddr/wdata      backdoor word write (byte address, word aligned)
module axi_read_responder #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter int          ID_WIDTH  = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [31:0]         i_axi_araddr,
  input  logic                i_axi_arvalid,
  output logic                o_axi_arready,
  input  logic [ID_WIDTH-1:0] i_axi_arid,
  input  logic [7:0]          i_axi_arlen,
  input  logic [2:0]          i_axi_arsize,
  input  logic [1:0]          i_axi_arburst,
  output logic [31:0]         o_axi_rdata,
  output logic                o_axi_rvalid,
  input  logic                i_axi_rready,
  output logic [1:0]          o_axi_rresp,
  output logic [ID_WIDTH-1:0] o_axi_rid,
  output logic                o_axi_rlast,
  input  logic                i_bd_wen,
  input  logic [31:0]         i_bd_waddr,
  input  logic [31:0]         i_bd_wdata
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  logic [31:0] mem [MEM_WORDS];

  state_t              state_q, state_d;
  logic [7:0]          delay_q, delay_d;
  logic [7:0]          beat_q, beat_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic                rvalid_q, rvalid_d;

  logic                src_ar;
  logic [31:0]         src_addr;
  logic [7:0]          src_len;
  logic [2:0]          src_size;
  logic [1:0]          src_burst;
  logic [ID_WIDTH-1:0] src_id;
  logic [7:0]          load_idx;
  logic                load_beat;
  logic [31:0]         beat_addr;
  logic [31:0]         beat_off;
  logic                beat_err;
  logic [31:0]         beat_data;
  logic [1:0]          beat_resp;
  logic                beat_last;
  logic [31:0]         bd_off;

  assign o_axi_arready = (state_q == S_IDLE);
  assign o_axi_rdata   = rdata_q;
  assign o_axi_rvalid  = rvalid_q;
  assign o_axi_rresp   = rresp_q;
  assign o_axi_rid     = rid_q;
  assign o_axi_rlast   = rlast_q;

  // With zero latency the first beat is built straight from the AR inputs.
  // Every later beat is built from the captured burst parameters.
  assign src_ar    = (state_q == S_IDLE);
  assign src_addr  = src_ar ? i_axi_araddr  : addr_q;
  assign src_len   = src_ar ? i_axi_arlen   : len_q;
  assign src_size  = src_ar ? i_axi_arsize  : size_q;
  assign src_burst = src_ar ? i_axi_arburst : burst_q;
  assign src_id    = src_ar ? i_axi_arid    : id_q;
  assign load_idx  = (state_q == S_BURST) ? beat_q + 8'd1 : 8'd0;

  // Beat contents for index load_idx. The offset subtraction wraps, so an
  // address below the base lands far above the window and reads as out of range.
  always_comb begin
    beat_addr = (src_burst == 2'b00) ? src_addr
                                     : src_addr + ({24'd0, load_idx} << src_size);
    beat_off  = beat_addr - ADDR_BASE;
    beat_err  = src_burst[1] || (src_size > 3'd2) || ((beat_off >> (AW + 2)) != 32'd0);
    beat_data = beat_err ? 32'd0 : mem[beat_off[AW+1:2]];
    beat_resp = beat_err ? 2'b10 : 2'b00;
    beat_last = (load_idx == src_len);
  end

  // Next-state logic. A beat register load happens on the edge that enters
  // BURST and on every non-final handshake. The final handshake drops rvalid,
  // which leaves at least one bubble before the next burst.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    id_d      = id_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rvalid_d  = rvalid_q;
    load_beat = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_axi_arvalid) begin
          addr_d  = i_axi_araddr;
          len_d   = i_axi_arlen;
          size_d  = i_axi_arsize;
          burst_d = i_axi_arburst;
          id_d    = i_axi_arid;
          if (LATENCY == 0) begin
            state_d   = S_BURST;
            load_beat = 1'b1;
          end else begin
            state_d = S_WAIT;
            delay_d = 8'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        if (delay_q <= 8'd1) begin
          state_d   = S_BURST;
          delay_d   = 8'd0;
          load_beat = 1'b1;
        end else begin
          delay_d = delay_q - 8'd1;
        end
      end
      S_BURST: begin
        if (i_axi_rready) begin
          if (rlast_q) begin
            state_d  = S_IDLE;
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
          end else begin
            load_beat = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_beat) begin
      rvalid_d = 1'b1;
      rdata_d  = beat_data;
      rresp_d  = beat_resp;
      rlast_d  = beat_last;
      rid_d    = src_id;
      beat_d   = load_idx;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      delay_q  <= 8'd0;
      beat_q   <= 8'd0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'd0;
      id_q     <= '0;
      rid_q    <= '0;
      rdata_q  <= 32'd0;
      rresp_q  <= 2'd0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      delay_q  <= delay_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      id_q     <= id_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rvalid_q <= rvalid_d;
    end
  end

  // The backdoor port ignores reset, so memory can be preloaded while the
  // core is held in reset. A beat loaded on the same edge sees the old word.
  assign bd_off = i_bd_waddr - ADDR_BASE;

  always_ff @(posedge i_clock) begin
    if (i_bd_wen && ((bd_off >> (AW + 2)) == 32'd0)) begin
      mem[bd_off[AW+1:2]] <= i_bd_wdata;
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder
//   Directed bench for axi_read_responder. It checks the reset state, INCR and
//   FIXED bursts, backpressure, error responses, the memory-window edge, and
//   reset in the middle of a burst.
module tb_axi_read_responder;

  localparam int LATENCY  = 2;
  localparam int ID_WIDTH = 4;

  logic                clk;
  logic                reset;
  logic [31:0]         araddr;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] arid;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [31:0]         rdata;
  logic                rvalid;
  logic                rready;
  logic [1:0]          rresp;
  logic [ID_WIDTH-1:0] rid;
  logic                rlast;
  logic                bd_wen;
  logic [31:0]         bd_waddr;
  logic [31:0]         bd_wdata;

  int n_checks;
  int n_fail;

  logic [31:0] exp_data [8];
  logic [1:0]  exp_resp [8];

  axi_read_responder #(
    .ADDR_BASE(32'h8000_0000),
    .MEM_WORDS(4096),
    .LATENCY  (LATENCY),
    .ID_WIDTH (ID_WIDTH)
  ) dut (
    .i_clock      (clk),
    .i_reset      (reset),
    .i_axi_araddr (araddr),
    .i_axi_arvalid(arvalid),
    .o_axi_arready(arready),
    .i_axi_arid   (arid),
    .i_axi_arlen  (arlen),
    .i_axi_arsize (arsize),
    .i_axi_arburst(arburst),
    .o_axi_rdata  (rdata),
    .o_axi_rvalid (rvalid),
    .i_axi_rready (rready),
    .o_axi_rresp  (rresp),
    .o_axi_rid    (rid),
    .o_axi_rlast  (rlast),
    .i_bd_wen     (bd_wen),
    .i_bd_waddr   (bd_waddr),
    .i_bd_wdata   (bd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bdWrite(input logic [31:0] addr, input logic [31:0] data);
    bd_wen   = 1'b1;
    bd_waddr = addr;
    bd_wdata = data;
    tick;
    bd_wen   = 1'b0;
  endtask

  // Present one AR request and hold it for the handshake edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst,
                               input logic [ID_WIDTH-1:0] id);
    araddr  = addr;
    arlen   = len;
    arsize  = size;
    arburst = burst;
    arid    = id;
    arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
  endtask

  // Run a full burst and compare it against exp_data/exp_resp. Optionally
  // hold rready low for stall_cycles before beat stall_beat is accepted.
  task automatic readBurst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [ID_WIDTH-1:0] id,
                           input int stall_beat, input int stall_cycles);
    int lat;
    checkOutput({tag, "_arready_before"}, {31'd0, arready}, 32'd1);
    rready = 1'b1;
    applyStimulus(addr, len, size, burst, id);
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick;
      lat++;
    end
    checkOutput({tag, "_first_beat_latency"}, 32'(lat), 32'(LATENCY));
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        rready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          tick;
          checkOutput({tag, "_stall_rvalid"}, {31'd0, rvalid}, 32'd1);
          checkOutput({tag, "_stall_rdata"}, rdata, exp_data[i]);
        end
        rready = 1'b1;
      end
      checkOutput($sformatf("%s_rvalid_b%0d", tag, i), {31'd0, rvalid}, 32'd1);
      checkOutput($sformatf("%s_rdata_b%0d", tag, i), rdata, exp_data[i]);
      checkOutput($sformatf("%s_rresp_b%0d", tag, i), {30'd0, rresp}, {30'd0, exp_resp[i]});
      checkOutput($sformatf("%s_rid_b%0d", tag, i), {28'd0, rid}, {28'd0, id});
      checkOutput($sformatf("%s_rlast_b%0d", tag, i), {31'd0, rlast},
                  (i == int'(len)) ? 32'd1 : 32'd0);
      tick;
    end
    checkOutput({tag, "_rvalid_after"}, {31'd0, rvalid}, 32'd0);
    checkOutput({tag, "_rlast_after"}, {31'd0, rlast}, 32'd0);
    checkOutput({tag, "_arready_after"}, {31'd0, arready}, 32'd1);
  endtask

  initial begin
    int lat;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    arvalid  = 1'b0;
    araddr   = 32'd0;
    arid     = '0;
    arlen    = 8'd0;
    arsize   = 3'd0;
    arburst  = 2'd0;
    rready   = 1'b1;
    bd_wen   = 1'b0;
    bd_waddr = 32'd0;
    bd_wdata = 32'd0;

    // Preload while reset is held; backdoor writes are honoured during reset.
    tick;
    bdWrite(32'h8000_0000, 32'h11);
    bdWrite(32'h8000_0004, 32'h22);
    bdWrite(32'h8000_0008, 32'h33);
    bdWrite(32'h8000_000C, 32'h44);
    bdWrite(32'h8000_3FFC, 32'hDEAD_BEEF);
    bdWrite(32'h8000_4000, 32'hBAD0_BAD0);
    reset = 1'b0;
    tick;
    $display("[TB] reset released");
    checkOutput("reset_arready", {31'd0, arready}, 32'd1);
    checkOutput("reset_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("reset_rlast", {31'd0, rlast}, 32'd0);
    checkOutput("reset_rdata", rdata, 32'd0);
    checkOutput("reset_rresp", {30'd0, rresp}, 32'd0);
    checkOutput("reset_rid", {28'd0, rid}, 32'd0);

    exp_data = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    exp_resp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    readBurst("incr4", 32'h8000_0000, 8'd3, 3'd2, 2'b01, 4'd5, -1, 0);

    exp_data = '{32'h22, 0, 0, 0, 0, 0, 0, 0};
    readBurst("single", 32'h8000_0004, 8'd0, 3'd2, 2'b01, 4'd2, -1, 0);

    exp_data = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    readBurst("stall", 32'h8000_0000, 8'd3, 3'd2, 2'b01, 4'd5, 1, 3);

    exp_data = '{32'h33, 32'h33, 32'h33, 0, 0, 0, 0, 0};
    readBurst("fixed", 32'h8000_0008, 8'd2, 3'd2, 2'b00, 4'd7, -1, 0);

    exp_data = '{0, 0, 0, 0, 0, 0, 0, 0};
    exp_resp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    readBurst("oor", 32'h0000_1000, 8'd1, 3'd2, 2'b01, 4'd1, -1, 0);
    readBurst("wrap", 32'h8000_0000, 8'd3, 3'd2, 2'b10, 4'd3, -1, 0);
    readBurst("size8", 32'h8000_0000, 8'd0, 3'd3, 2'b01, 4'd4, -1, 0);

    // Last word of the window is OKAY; the next word is past the end.
    exp_data = '{32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0};
    exp_resp = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    readBurst("edge", 32'h8000_3FFC, 8'd1, 3'd2, 2'b01, 4'd6, -1, 0);

    // Byte-sized beats stay inside the same aligned word.
    exp_data = '{32'h11, 32'h11, 0, 0, 0, 0, 0, 0};
    exp_resp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    readBurst("bytes", 32'h8000_0000, 8'd1, 3'd0, 2'b01, 4'd8, -1, 0);

    // Reset in the middle of a len7 burst, after two beats are accepted.
    rready = 1'b1;
    applyStimulus(32'h8000_0000, 8'd7, 3'd2, 2'b01, 4'd9);
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick;
      lat++;
    end
    checkOutput("midreset_latency", 32'(lat), 32'(LATENCY));
    checkOutput("midreset_beat0", rdata, 32'h11);
    tick;
    checkOutput("midreset_beat1", rdata, 32'h22);
    tick;
    reset = 1'b1;
    tick;
    checkOutput("midreset_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("midreset_rlast", {31'd0, rlast}, 32'd0);
    checkOutput("midreset_rdata", rdata, 32'd0);
    reset = 1'b0;
    tick;
    checkOutput("midreset_arready", {31'd0, arready}, 32'd1);
    checkOutput("midreset_no_beats", {31'd0, rvalid}, 32'd0);

    exp_data = '{32'h11, 0, 0, 0, 0, 0, 0, 0};
    readBurst("after_reset", 32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd4, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
